// File: rtl/mem_access_unit.sv
// Load/store master for a single-port word RAM: byte/halfword lane select with
// sign/zero extension, read-modify-write for sub-word stores, alignment checks.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  ram_en,
  output logic                  ram_wr,
  output logic [ADDR_WIDTH-3:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  state_t          state;
  logic [1:0]      lo_q;
  logic [1:0]      size_q;
  logic            sgn_q;
  logic [15:0]     wd_q;
  logic            ram_en_q;
  logic            misaligned;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [DATA_WIDTH-1:0] load_val;
  logic [DATA_WIDTH-1:0] merge_val;

  // The RAM must never see an access while reset is held, even mid-operation.
  assign ram_en = ram_en_q & ~reset;

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = (req_addr[1:0] != 2'b00);
      2'b11:   misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    byte_v    = ram_rdata[{lo_q, 3'b000} +: 8];
    half_v    = ram_rdata[{lo_q[1], 4'b0000} +: 16];
    load_val  = ram_rdata;
    merge_val = ram_rdata;
    case (size_q)
      2'b00: begin
        load_val = {{(DATA_WIDTH-8){sgn_q & byte_v[7]}}, byte_v};
        merge_val[{lo_q, 3'b000} +: 8] = wd_q[7:0];
      end
      2'b01: begin
        load_val = {{(DATA_WIDTH-16){sgn_q & half_v[15]}}, half_v};
        merge_val[{lo_q[1], 4'b0000} +: 16] = wd_q;
      end
      default: begin
        load_val  = ram_rdata;
        merge_val = ram_rdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_wr     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      lo_q       <= '0;
      size_q     <= '0;
      sgn_q      <= 1'b0;
      wd_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            lo_q      <= req_addr[1:0];
            size_q    <= req_size;
            sgn_q     <= req_signed;
            wd_q      <= req_wdata[15:0];
            if (misaligned) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              ram_en_q <= 1'b1;
              ram_addr <= req_addr[ADDR_WIDTH-1:2];
              if (!req_wr) begin
                state  <= LOAD;
                ram_wr <= 1'b0;
              end else if (req_size == 2'b10) begin
                state     <= WRITE;
                ram_wr    <= 1'b1;
                ram_wdata <= req_wdata;
              end else begin
                state  <= RMW_RD;
                ram_wr <= 1'b0;
              end
            end
          end
        end
        LOAD: begin
          state      <= RESP;
          ram_en_q   <= 1'b0;
          ram_addr   <= '0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= load_val;
        end
        RMW_RD: begin
          state     <= WRITE;
          ram_wr    <= 1'b1;
          ram_wdata <= merge_val;
        end
        WRITE: begin
          state      <= RESP;
          ram_en_q   <= 1'b0;
          ram_wr     <= 1'b0;
          ram_addr   <= '0;
          ram_wdata  <= '0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit with a behavioural RAM and
// an arithmetic reference model of memory contents and load results.
module tb_mem_access_unit;
  localparam int AW = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ram_en;
  logic        ram_wr;
  logic [AW-3:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  mem_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .ram_en(ram_en),
    .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM
  logic [31:0] mem [0:1023];
  logic [31:0] init_val [0:1023];
  logic        ram_init = 1'b1;
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val[i];
    end else if (ram_en && ram_wr) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct { logic [31:0] rdata; logic err; } resp_t;
  resp_t       sbq[$];
  logic [31:0] ref_mem [0:1023];
  int          en_cnt = 0;
  int          wr_cnt = 0;
  logic [9:0]  exp_waddr = '0;

  // Monitor: RAM-side checks and response scoreboard
  logic        prev_hold = 1'b0;
  logic [31:0] prev_rdata;
  logic        prev_err;
  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (ram_en) begin
        en_cnt++;
        if (ram_wr) wr_cnt++;
        check("ram_addr", {22'd0, ram_addr}, {22'd0, exp_waddr});
      end else begin
        check("ram_addr_idle", {22'd0, ram_addr}, 32'd0);
      end
      if (!(ram_en && ram_wr)) check("ram_wdata_idle", ram_wdata, 32'd0);
      if (resp_valid) begin
        check("resp_req_ready", {31'd0, req_ready}, 32'd0);
        check("resp_ram_en", {31'd0, ram_en}, 32'd0);
        if (prev_hold) begin
          check("stall_rdata", resp_rdata, prev_rdata);
          check("stall_err", {31'd0, resp_err}, {31'd0, prev_err});
        end
        if (resp_ready) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got rdata %h err %b expected none", resp_rdata, resp_err);
          end else begin
            resp_t e;
            e = sbq.pop_front();
            check("resp_rdata", resp_rdata, e.rdata);
            check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
          end
          prev_hold = 1'b0;
        end else begin
          prev_hold  = 1'b1;
          prev_rdata = resp_rdata;
          prev_err   = resp_err;
        end
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
    check({tag, "_ram_en"}, {31'd0, ram_en}, 32'd0);
    check({tag, "_ram_wr"}, {31'd0, ram_wr}, 32'd0);
    check({tag, "_ram_addr"}, {22'd0, ram_addr}, 32'd0);
    check({tag, "_ram_wdata"}, ram_wdata, 32'd0);
  endtask

  // Called at #1 after a posedge with the DUT idle.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sgn,
                        input logic [AW-1:0] addr, input logic [31:0] wd, input int stall);
    int          wa, lo, lat_e, en_e, wr_e, lat, n;
    logic [31:0] w, v, mask;
    int          sh;
    bit          mis;
    resp_t       e;
    wa  = int'(addr[AW-1:2]);
    lo  = int'(addr[1:0]);
    mis = (sz == 2'b11) || (sz == 2'b01 && lo % 2 != 0) || (sz == 2'b10 && lo != 0);
    if (mis) begin
      e.rdata = 0; e.err = 1'b1; lat_e = 1; en_e = 0; wr_e = 0;
    end else if (!wr) begin
      w = ref_mem[wa];
      if (sz == 2'b00) begin
        v = (w >> (8 * lo)) & 32'hFF;
        if (sgn && v >= 128) v = v | 32'hFFFFFF00;
      end else if (sz == 2'b01) begin
        v = (w >> (16 * (lo / 2))) & 32'hFFFF;
        if (sgn && v >= 32768) v = v | 32'hFFFF0000;
      end else begin
        v = w;
      end
      e.rdata = v; e.err = 1'b0; lat_e = 2; en_e = 1; wr_e = 0;
    end else if (sz == 2'b10) begin
      ref_mem[wa] = wd;
      e.rdata = 0; e.err = 1'b0; lat_e = 2; en_e = 1; wr_e = 1;
    end else begin
      mask = (sz == 2'b00) ? 32'hFF : 32'hFFFF;
      sh   = (sz == 2'b00) ? 8 * lo : 16 * (lo / 2);
      ref_mem[wa] = (ref_mem[wa] & ~(mask << sh)) | ((wd & mask) << sh);
      e.rdata = 0; e.err = 1'b0; lat_e = 3; en_e = 2; wr_e = 1;
    end
    sbq.push_back(e);
    exp_waddr  = addr[AW-1:2];
    req_valid  = 1'b1;
    req_wr     = wr;
    req_size   = sz;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wd;
    resp_ready = (stall == 0);
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    check("accept_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    en_cnt = 0;
    wr_cnt = 0;
    lat = 1;
    while (!resp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    check("latency", lat, lat_e);
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1 resp_ready = 1'b1;
    end
    n = 0;
    while (resp_valid && n < 10) begin @(posedge clk); #1; n++; end
    check("resp_consumed", {31'd0, resp_valid}, 32'd0);
    check("req_ready_back", {31'd0, req_ready}, 32'd1);
    check("ram_en_cycles", en_cnt, en_e);
    check("ram_wr_cycles", wr_cnt, wr_e);
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 1024; i++) begin
      init_val[i] = $urandom;
      ref_mem[i]  = init_val[i];
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;
    ram_init = 1'b0;
    @(posedge clk); #1;

    // Word store then load
    do_req(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 0);
    do_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 0);
    // Byte store RMW (upper wdata bits ignored)
    do_req(1'b1, 2'b10, 1'b0, 12'h010, 32'h11223344, 0);
    do_req(1'b1, 2'b00, 1'b0, 12'h012, 32'hFFFFFFAB, 0);
    do_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 0);
    // Signed/unsigned lane loads
    do_req(1'b1, 2'b10, 1'b0, 12'h010, 32'h80FF7F01, 0);
    do_req(1'b0, 2'b00, 1'b1, 12'h011, 32'h0, 0);
    do_req(1'b0, 2'b00, 1'b1, 12'h012, 32'h0, 0);
    do_req(1'b0, 2'b01, 1'b0, 12'h012, 32'h0, 0);
    do_req(1'b0, 2'b01, 1'b1, 12'h012, 32'h0, 0);
    // Misalignment and reserved size
    do_req(1'b0, 2'b01, 1'b0, 12'h013, 32'h0, 0);
    do_req(1'b1, 2'b10, 1'b0, 12'h016, 32'h12345678, 0);
    do_req(1'b0, 2'b11, 1'b0, 12'h010, 32'h0, 0);
    do_req(1'b0, 2'b10, 1'b0, 12'h014, 32'h0, 0);
    // Response backpressure
    do_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 5);

    for (int t = 0; t < 300; t++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 63));
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, $urandom_range(0, 3));
    end

    // Reset during RMW_RD of a byte store
    exp_waddr  = 10'h005;
    req_valid  = 1'b1;
    req_wr     = 1'b1;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 12'h015;
    req_wdata  = 32'h000000CD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rmw_rd_en", {31'd0, ram_en}, 32'd1);
    check("rmw_rd_wr", {31'd0, ram_wr}, 32'd0);
    reset = 1'b1;
    #1 check("reset_forces_en", {31'd0, ram_en}, 32'd0);
    @(posedge clk); #1;
    check_reset_vals("midreset");
    reset = 1'b0;
    @(posedge clk); #1;
    do_req(1'b0, 2'b10, 1'b0, 12'h014, 32'h0, 0);

    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem_contents_mismatches", bad, 0);
    check("scoreboard_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side master for the single-port word RAM. Turns byte-addressed load/store requests from the CPU pipeline into RAM word accesses.
- Performs sub-word (byte/halfword) extraction and sign/zero extension on loads, read-modify-write merging on sub-word stores, and alignment checking.
- Sits between the pipeline MEM stage and the data RAM, with a valid/ready request channel and a valid/ready response channel.

Parameters:
- ADDR_WIDTH, 12, byte-address width; RAM word address is ADDR_WIDTH-2 bits.
- DATA_WIDTH, 32, fixed RAM word width; other values unsupported.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request
- req_wr  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned)
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  input  ADDR_WIDTH  byte address
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  response present
- resp_ready  input  1  consumer takes response
- resp_rdata  output  32  load result (0 for stores and errors)
- resp_err  output  1  misaligned or reserved-size request
- ram_en  output  1  RAM enable, active-high
- ram_wr  output  1  1 = write, 0 = read
- ram_addr  output  ADDR_WIDTH-2  word address = req_addr[ADDR_WIDTH-1:2]
- ram_wdata  output  32  RAM write data
- ram_rdata  input  32  RAM read data, combinational from ram_addr while ram_en=1

Behaviour:
- Reset: state IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, ram_en=0, ram_wr=0, ram_addr=0, ram_wdata=0. ram_en is combinationally forced to 0 while reset=1, so no RAM access occurs even if reset is asserted mid-operation. Reset mid-operation abandons the request and drops any pending response.
- FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE: req_ready=1. On req_valid=1, capture the request and evaluate alignment. A request is misaligned if size=01 with addr[0]=1, size=10 with addr[1:0]!=0, or size=11.
  - misaligned -> RESP with err=1
  - load -> LOAD
  - word store -> WRITE (wdata register = req_wdata)
  - byte or halfword store -> RMW_RD
- req_ready=0 in every state other than IDLE. Only one request is outstanding at a time.
- LOAD: ram_en=1, ram_wr=0. Select the lane: byte = word[8*addr[1:0]+:8], half = word[16*addr[1]+:16], little-endian. Extend per req_signed and register into resp_rdata, then -> RESP.
- RMW_RD: ram_en=1, ram_wr=0. Merge req_wdata low byte/half into the selected lane of ram_rdata, leaving other lanes unchanged; register the merged word, then -> WRITE.
- WRITE: ram_en=1, ram_wr=1, ram_wdata = registered word. The RAM commits at the closing edge, then -> RESP.
- RESP: resp_valid=1, resp_rdata and resp_err held stable. On resp_ready=1 -> IDLE. No request is accepted in the same cycle.
- ram_addr holds the captured word address in LOAD, RMW_RD and WRITE, and 0 otherwise. ram_wdata is 0 outside WRITE.
- Latency from the accept edge to resp_valid:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- Back-to-back minimum period is latency + 1 when resp_ready is held at 1.
- req_wdata bits above the access size are ignored. resp_rdata=0 on store and error responses.
- Stalled response (resp_ready=0): stay in RESP indefinitely with outputs stable and ram_en=0.

Test Plan:
- Word store then load: store addr 0x010 data 0xDEADBEEF -> one WRITE cycle with ram_addr=0x004 and ram_wdata=0xDEADBEEF; a following word load returns 0xDEADBEEF, err=0, resp_valid 2 cycles after accept.
- Byte store RMW: RAM word 4 = 0x11223344, store byte 0xAB to addr 0x012 -> RMW_RD then WRITE of 0x11AB3344; the total of RAM-enabled cycles is exactly 2.
- Signed/unsigned loads from word 0x80FF7F01:
  - byte at +1, signed -> 0x0000007F
  - byte at +2, signed -> 0xFFFFFFFF
  - half at +2, unsigned -> 0x000080FF
  - half at +2, signed -> 0xFFFF80FF
- Misalignment: half load at 0x013, word store at 0x016, size=11 -> resp_err=1 and resp_rdata=0 one cycle after accept; ram_en stays 0 throughout and RAM contents are unchanged.
- Response backpressure: hold resp_ready=0 for 5 cycles after a load -> resp_valid and data stable, req_ready=0, ram_en=0; accept occurs only after the cycle in which resp_ready=1.
- Reset asserted during RMW_RD of a byte store -> ram_en=0 from that cycle, no write occurs, the original word is intact, and all outputs equal their reset values after the edge.
